// File: rtl/mpa_pkg.sv
// mpa_pkg: shared constants and types for the multi-precision row engine.
package mpa_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_WORDS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/MultiplyAdd.sv
// MultiplyAdd: {cout, s} = x*y + z + cin, purely combinational.
// The result always fits in 2*WIDTH bits, so no overflow path exists.
module MultiplyAdd #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] cin,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] cout
);

    logic [2*WIDTH-1:0] w_full;

    // Double-width multiply-accumulate, split into low and high words
    always_comb begin
        w_full = ({{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y})
               + {{WIDTH{1'b0}}, z}
               + {{WIDTH{1'b0}}, cin};
        s      = w_full[WIDTH-1:0];
        cout   = w_full[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/mpa_row_sequencer.sv
// mpa_row_sequencer: computes R = A*b + Z one word per cycle by walking the
// A/Z word memories, feeding MultiplyAdd and chaining the carry word.
// Optional build macro MPA_ABORT_EN adds the abort input / aborted output.
module mpa_row_sequencer
    import mpa_pkg::*;
#(
    parameter int DATA_WIDTH = mpa_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mpa_pkg::ADDR_WIDTH,
    parameter int NUM_WORDS  = mpa_pkg::NUM_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] a_rdata,
    input  logic [DATA_WIDTH-1:0] z_rdata,
    output logic                  r_we,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_wdata,
`ifdef MPA_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    output logic [DATA_WIDTH-1:0] carry_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_carry;
    logic [DATA_WIDTH-1:0] r_carry_out;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_idx;
    // Set once the word for r_idx is present on the read-data inputs
    logic                  r_wr_phase;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_abort;
    logic [DATA_WIDTH-1:0] w_s;
    logic [DATA_WIDTH-1:0] w_cout;
`ifdef MPA_ABORT_EN
    logic                  r_aborted;
`endif

    MultiplyAdd #(
        .WIDTH (DATA_WIDTH)
    ) u_mul_add (
        .x    (a_rdata),
        .y    (r_b),
        .z    (z_rdata),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // Abort request is only meaningful while a row is running
    always_comb begin
`ifdef MPA_ABORT_EN
        w_abort = abort && (r_state == RUN);
`else
        w_abort = 1'b0;
`endif
    end

    // Row controller: index/read counters, carry chain and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_b         <= '0;
            r_carry     <= '0;
            r_carry_out <= '0;
            r_rd_addr   <= '0;
            r_idx       <= '0;
            r_wr_phase  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef MPA_ABORT_EN
            r_aborted   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
`ifdef MPA_ABORT_EN
                    r_aborted <= 1'b0;
`endif
                    if (start) begin
                        r_b        <= b;
                        r_carry    <= '0;
                        r_rd_addr  <= '0;
                        r_idx      <= '0;
                        r_wr_phase <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_rd_addr  <= '0;
                        r_idx      <= '0;
                        r_wr_phase <= 1'b0;
`ifdef MPA_ABORT_EN
                        r_aborted  <= 1'b1;
`endif
                    end else begin
                        // Read address runs one word ahead of the write index
                        if (r_rd_addr != LAST_IDX) begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                        r_wr_phase <= 1'b1;
                        if (r_wr_phase) begin
                            r_carry <= w_cout;
                            if (r_idx == LAST_IDX) begin
                                r_carry_out <= w_cout;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= DONE;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    r_done     <= 1'b0;
                    r_rd_addr  <= '0;
                    r_idx      <= '0;
                    r_wr_phase <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Write port is driven straight from the registered index and datapath
    always_comb begin
        r_we    = (r_state == RUN) && r_wr_phase && !w_abort;
        r_addr  = r_idx;
        r_wdata = w_s;
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_addr   = r_rd_addr;
    assign carry_out = r_carry_out;
`ifdef MPA_ABORT_EN
    assign aborted   = r_aborted;
`endif

endmodule

// File: tb/tb_mpa_row_sequencer.sv
// tb_mpa_row_sequencer: random rows checked against a wide-integer model of
// R = A*b + Z (1088-bit), plus start-held, reset-abandon and abort scenarios.
module tb_mpa_row_sequencer;

    localparam int NW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [3:0]  rd_addr;
    logic [63:0] a_rdata;
    logic [63:0] z_rdata;
    logic        r_we;
    logic [3:0]  r_addr;
    logic [63:0] r_wdata;
    logic [63:0] carry_out;
`ifdef MPA_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    logic [63:0] A_mem [NW];
    logic [63:0] Z_mem [NW];
    logic [63:0] exp_carry;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mpa_row_sequencer #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (4),
        .NUM_WORDS  (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .a_rdata   (a_rdata),
        .z_rdata   (z_rdata),
        .r_we      (r_we),
        .r_addr    (r_addr),
        .r_wdata   (r_wdata),
`ifdef MPA_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .carry_out (carry_out)
    );

    // Synchronous-read A and Z word memories
    always @(posedge clk) begin
        a_rdata <= A_mem[rd_addr];
        z_rdata <= Z_mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Whole-operand reference: treat A and Z as 1024-bit integers
    function automatic logic [1087:0] ref_row(input logic [63:0] bv);
        logic [1087:0] a_big;
        logic [1087:0] z_big;
        a_big = '0;
        z_big = '0;
        for (int i = 0; i < NW; i++) begin
            a_big[64*i +: 64] = A_mem[i];
            z_big[64*i +: 64] = Z_mem[i];
        end
        return a_big * {1024'b0, bv} + z_big;
    endfunction

    // mode 0: full row; mode 1: reset after write stop_idx; mode 2: abort after write stop_idx
    task automatic run_row(input logic [63:0] bval, input int mode, input int stop_idx);
        logic [1087:0] res;
        int  k;
        int  nwr;
        int  extra;
        int  dn;
        int  ab;
        bit  fin;
        bit  got_done;
        bit  stopped;
        res      = ref_row(bval);
        k        = 0;
        nwr      = 0;
        fin      = 1'b0;
        got_done = 1'b0;
        stopped  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        b     = bval;
        @(posedge clk);
        #1;
        start = 1'b0;
        b     = rand64();
        while (!fin && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk("busy_first", busy, 1);
                chk("we_first", r_we, 0);
                chk("rd_addr_first", rd_addr, 0);
            end
            if (r_we) begin
                chk("wr_addr", r_addr, nwr);
                if (nwr < NW) chk("wr_data", r_wdata, res[64*nwr +: 64]);
                chk("wr_cycle", k, nwr + 2);
                chk("wr_busy", busy, 1);
                nwr++;
                if (mode != 0 && nwr - 1 == stop_idx) begin
                    if (mode == 1) reset = 1'b1;
`ifdef MPA_ABORT_EN
                    else abort = 1'b1;
`endif
                    @(negedge clk);
                    k++;
                    chk("stop_we", r_we, 0);
                    chk("stop_busy", busy, 0);
                    chk("stop_done", done, 0);
                    if (mode == 1) begin
                        chk("rst_rd_addr", rd_addr, 0);
                        chk("rst_r_addr", r_addr, 0);
                        chk("rst_carry", carry_out, 0);
                        exp_carry = '0;
                    end
`ifdef MPA_ABORT_EN
                    else begin
                        chk("aborted_pulse", aborted, 1);
                        chk("abort_carry", carry_out, exp_carry);
                    end
                    abort = 1'b0;
`endif
                    reset = 1'b0;
                    extra = 0;
                    dn    = 0;
                    ab    = 0;
                    repeat (25) begin
                        @(negedge clk);
                        if (r_we) extra++;
                        if (done) dn++;
`ifdef MPA_ABORT_EN
                        if (aborted) ab++;
`endif
                    end
                    chk("post_stop_writes", extra, 0);
                    chk("post_stop_done", dn, 0);
                    chk("post_stop_aborted", ab, 0);
                    chk("post_stop_carry", carry_out, exp_carry);
                    stopped = 1'b1;
                    fin     = 1'b1;
                end
            end
            if (!fin && done) begin
                got_done = 1'b1;
                fin      = 1'b1;
            end
        end
        if (mode == 0) begin
            chk("done_seen", got_done, 1);
            chk("done_cycle", k, 18);
            chk("write_count", nwr, NW);
            chk("busy_in_done", busy, 0);
            chk("carry_out", carry_out, res[1087:1024]);
            exp_carry = res[1087:1024];
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("rd_addr_idle", rd_addr, 0);
            chk("carry_hold", carry_out, exp_carry);
        end else begin
            chk("stop_reached", stopped, 1);
        end
    endtask

    // start held high: two rows separated by the DONE cycle, then release
    task automatic run_held();
        logic [1087:0] res;
        logic [63:0]   bval;
        int nwr;
        int ndone;
        bval  = rand64();
        res   = ref_row(bval);
        nwr   = 0;
        ndone = 0;
        @(negedge clk);
        start = 1'b1;
        b     = bval;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (r_we) begin
                chk("held_addr", r_addr, nwr % NW);
                chk("held_data", r_wdata, res[64*(nwr % NW) +: 64]);
                nwr++;
            end
            if (done) begin
                ndone++;
                chk("held_done_cyc", c, (ndone == 1) ? 18 : 37);
                chk("held_carry", carry_out, res[1087:1024]);
            end
            if (c == 38) start = 1'b0;
        end
        chk("held_writes", nwr, 2 * NW);
        chk("held_dones", ndone, 2);
        chk("held_idle_busy", busy, 0);
        exp_carry = res[1087:1024];
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) begin
            A_mem[i] = rand64();
            Z_mem[i] = rand64();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        b     = '0;
        exp_carry = '0;
`ifdef MPA_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < NW; i++) begin
            A_mem[i] = '0;
            Z_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", r_we, 0);
        chk("rst_rd_addr0", rd_addr, 0);
        chk("rst_r_addr0", r_addr, 0);
        chk("rst_carry0", carry_out, 0);
        reset = 1'b0;
        @(negedge clk);

        // All-ones operands: maximal carries
        for (int i = 0; i < NW; i++) begin
            A_mem[i] = '1;
            Z_mem[i] = '1;
        end
        run_row(64'hFFFF_FFFF_FFFF_FFFF, 0, 0);

        // b = 0: result is Z, b must be latched at start
        for (int i = 0; i < NW; i++) begin
            A_mem[i] = rand64();
            Z_mem[i] = 64'(i);
        end
        run_row(64'd0, 0, 0);

        // Carry ripple from Z[0] overflow
        for (int i = 0; i < NW; i++) begin
            A_mem[i] = 64'd1;
            Z_mem[i] = '0;
        end
        Z_mem[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_row(64'd5, 0, 0);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_row(rand64(), 0, 0);
        end

        fill_random();
        run_held();

        fill_random();
        run_row(rand64(), 1, 7);
        run_row(rand64(), 0, 0);

`ifdef MPA_ABORT_EN
        // abort while idle is ignored
        @(negedge clk);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_abort_aborted", aborted, 0);
        chk("idle_abort_busy", busy, 0);
        abort = 1'b0;
        fill_random();
        run_row(rand64(), 0, 0);
        run_row(rand64(), 2, 3);
        run_row(rand64(), 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mpa_row_sequencer.md
Name: mpa_row_sequencer

Overview:
Sequences the team's 64-bit multiply-add unit (MultiplyAdd: s/cout = x*y + z + cin) across a multi-word operand to compute R = A*b + Z. A and Z are NUM_WORDS-word operands held in synchronous-read word memories; b is a single word. Each result word goes to an R memory, and the final carry word goes to a register. This is the inner row engine for the 1024-bit RSA Montgomery/modexp datapath.

Parameters:
DATA_WIDTH, 64, word width
ADDR_WIDTH, 4, word address width
NUM_WORDS, 16, words per operand; must satisfy 1 <= NUM_WORDS <= 2**ADDR_WIDTH

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
b  in  DATA_WIDTH  multiplier word; latched when start is accepted
busy  out  1  high from acceptance+1 through the last write cycle
done  out  1  one-cycle pulse after the last write
rd_addr  out  ADDR_WIDTH  registered read address, shared by the A and Z memories
a_rdata  in  DATA_WIDTH  A word; valid one cycle after rd_addr
z_rdata  in  DATA_WIDTH  Z word; valid one cycle after rd_addr
r_we  out  1  R write enable
r_addr  out  ADDR_WIDTH  R write address
r_wdata  out  DATA_WIDTH  R write data, equal to MultiplyAdd s
carry_out  out  DATA_WIDTH  final carry word (top word of result), registered

Behaviour:
- Reset state:
  - State is IDLE.
  - busy, done, and r_we are 0; rd_addr and r_addr are 0; carry_out is 0.
  - The internal carry register and latched b are 0.
  - Reset mid-operation abandons the row immediately. No further writes occur and done does not pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge T latches b, clears the carry register, sets rd_addr=0, and moves to RUN.
- RUN:
  - Cycle T+1 presents rd_addr=0.
  - In cycle T+2+i, for i = 0..NUM_WORDS-1:
    - the datapath computes x=a_rdata, y=b_latched, z=z_rdata, cin=carry_reg;
    - r_we=1, r_addr=i, r_wdata=s (all combinational from the registered index);
    - carry_reg <= cout at the end of the cycle.
  - rd_addr increments each cycle until it reaches NUM_WORDS-1, then holds.
  - At the end of the last write cycle (T+1+NUM_WORDS): carry_out <= cout, state moves to DONE.
- DONE:
  - done=1 for exactly one cycle (T+2+NUM_WORDS); r_we=0; then IDLE.
- Latency: start accepted at edge T means done is high in cycle T+NUM_WORDS+2. With the default that is 18 cycles, and 16 consecutive writes with no gaps.
- busy = 1 in cycles T+1 .. T+1+NUM_WORDS; it is 0 in DONE and IDLE.
- start is ignored outside IDLE, including in the DONE cycle. There is no queuing.
- Arithmetic rules:
  - The product plus two words always fits in 2*DATA_WIDTH bits, since (2^W-1)^2 + 2(2^W-1) = 2^(2W)-1. No overflow handling is needed.
  - carry_out holds its value until the next accepted start; it is not cleared at start.
- NUM_WORDS=1: one write at T+2, done at T+3.
- rd_addr never exceeds NUM_WORDS-1. It returns to 0 on the edge entering IDLE.

Optional Feature:
MPA_ABORT_EN
- With the macro defined:
  - adds input abort (1) and output aborted (1).
  - abort=1 while busy: the next edge goes to IDLE, r_we is forced to 0 in that same cycle, no done pulse is issued, aborted pulses for one cycle, and carry_out is unchanged.
  - abort in IDLE or DONE has no effect.
  - reset has priority over abort.
- Without the macro: neither port exists, and behaviour is exactly as above.

Decomposition:
- Package mpa_pkg holds:
  - constants DATA_WIDTH, ADDR_WIDTH, NUM_WORDS;
  - typedef for the FSM state enum (IDLE/RUN/DONE);
  - typedefs word_t (DATA_WIDTH) and addr_t (ADDR_WIDTH).
- One sub-module: the existing MultiplyAdd, instantiated once, fed combinationally from a_rdata, z_rdata, latched b, and carry_reg.
- Counter, FSM, and carry register stay in mpa_row_sequencer.

Test Plan:
1. A=Z=all-ones words, b=0xFFFF_FFFF_FFFF_FFFF -> R[0]=0, R[1..15]=0xFFFF_FFFF_FFFF_FFFF, carry_out=0xFFFF_FFFF_FFFF_FFFF, done exactly 18 cycles after start.
2. b=0, Z[i]=i, A random -> R[i]=i, carry_out=0. Also check b is latched: changing b after start has no effect.
3. A[i]=1, b=5, Z[0]=0xFFFF_FFFF_FFFF_FFFF, other Z=0 -> R[0]=4, R[1]=6, R[2..15]=5, carry_out=0. Carry propagation is checked against a 1088-bit reference model.
4. start held high continuously for 40 cycles -> two rows back-to-back, separated by the DONE cycle; exactly 32 writes; start pulses during busy ignored.
5. Reset asserted at write index 7 -> r_we=0 on the following cycle, all outputs at reset values, no done; a fresh start then runs a normal row.
6. (MPA_ABORT_EN) abort at write index 3 -> writes stop after index 3, aborted pulses once, done stays 0, previous carry_out retained.
